// File: rtl/mem_wb_stage.sv
// rtl/mem_wb_stage.sv - memory stage plus MEM/WB pipeline register of the 16-bit pipelined MIPS core
//
// Purpose:
//   Resolves the branch decision, performs the data-memory access and registers
//   the write-back bundle for the WB stage. When MEM_WAIT_STATE_EN is defined, a
//   two-state load wait-state FSM inserts one stall cycle (and one WB bubble) per
//   load. With MEM_WAIT_STATE_EN undefined, stall is tied low and every enabled
//   edge commits.
//
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   en                            pipeline advance enable
//   *_out_pipe_3                  EX/MEM bundle (controls, flags, target, ALU result,
//                                 store data, destination register)
//   pcSrc, branch_target_mem      combinational branch decision and target
//   stall                         load wait-state active, upstream must hold
//   *_out_pipe_4                  registered MEM/WB bundle for write-back
//
// Parameters:
//   DATA_W  data/address width
//   ADDR_W  data-memory index width (depth 2^ADDR_W words)

module mem_wb_stage #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              branch_out_pipe_3,
    input  logic              memWrite_out_pipe_3,
    input  logic              memRead_out_pipe_3,
    input  logic              memtoReg_out_pipe_3,
    input  logic              regWrite_out_pipe_3,
    input  logic              zero_out_pipe_3,
    input  logic [DATA_W-1:0] branch_target_out_pipe_3,
    input  logic [DATA_W-1:0] aluResult_out_pipe_3,
    input  logic [DATA_W-1:0] read_data_2_out_pipe_3,
    input  logic [2:0]        write_reg_ex_out_pipe_3,
    output logic              pcSrc,
    output logic [DATA_W-1:0] branch_target_mem,
    output logic              stall,
    output logic              memtoReg_out_pipe_4,
    output logic              regWrite_out_pipe_4,
    output logic [DATA_W-1:0] read_data_out_pipe_4,
    output logic [DATA_W-1:0] aluResult_out_pipe_4,
    output logic [2:0]        write_reg_out_pipe_4
);

    localparam int DEPTH = 1 << ADDR_W;

    // Branch resolution is purely combinational so IF can redirect this cycle.
    assign pcSrc             = branch_out_pipe_3 & zero_out_pipe_3;
    assign branch_target_mem = branch_target_out_pipe_3;

    // Only the low ADDR_W bits index the memory; the rest wrap silently.
    logic [ADDR_W-1:0] mem_addr;
    logic              unused_addr_bits;
    assign mem_addr         = aluResult_out_pipe_3[ADDR_W-1:0];
    assign unused_addr_bits = ^aluResult_out_pipe_3[DATA_W-1:ADDR_W];

    logic stall_int;
    logic commit;
    logic bubble;

`ifdef MEM_WAIT_STATE_EN
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    state_t state_q;
    state_t state_d;

    // A load first stalls in IDLE, then commits from WAIT. If en drops the FSM holds.
    always_comb begin
        state_d   = state_q;
        stall_int = 1'b0;
        case (state_q)
            ST_IDLE: begin
                stall_int = memRead_out_pipe_3;
                if (en && memRead_out_pipe_3) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (en) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end
`else
    logic unused_mem_read;
    assign stall_int       = 1'b0;
    assign unused_mem_read = memRead_out_pipe_3;
`endif

    assign stall  = stall_int;
    assign commit = en & ~stall_int;
    assign bubble = en & stall_int;

    // Data memory: no reset, written only on a commit edge. The registered read
    // below samples the array before this edge's write lands (read-before-write).
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_we;

    assign mem_rdata = mem_q[mem_addr];
    assign mem_we    = commit & memWrite_out_pipe_3;

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[mem_addr] <= read_data_2_out_pipe_3;
        end
    end

    // MEM/WB register
    logic              memtoreg_q, memtoreg_d;
    logic              regwrite_q, regwrite_d;
    logic [DATA_W-1:0] read_data_q, read_data_d;
    logic [DATA_W-1:0] alu_result_q, alu_result_d;
    logic [2:0]        write_reg_q, write_reg_d;

    always_comb begin
        memtoreg_d   = memtoreg_q;
        regwrite_d   = regwrite_q;
        read_data_d  = read_data_q;
        alu_result_d = alu_result_q;
        write_reg_d  = write_reg_q;
        if (commit) begin
            memtoreg_d   = memtoReg_out_pipe_3;
            regwrite_d   = regWrite_out_pipe_3;
            read_data_d  = mem_rdata;
            alu_result_d = aluResult_out_pipe_3;
            write_reg_d  = write_reg_ex_out_pipe_3;
        end else if (bubble) begin
            // Stall cycle: hand WB a bubble, keep data fields as they were.
            memtoreg_d = 1'b0;
            regwrite_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            memtoreg_q   <= 1'b0;
            regwrite_q   <= 1'b0;
            read_data_q  <= '0;
            alu_result_q <= '0;
            write_reg_q  <= '0;
        end else begin
            memtoreg_q   <= memtoreg_d;
            regwrite_q   <= regwrite_d;
            read_data_q  <= read_data_d;
            alu_result_q <= alu_result_d;
            write_reg_q  <= write_reg_d;
        end
    end

    assign memtoReg_out_pipe_4  = memtoreg_q;
    assign regWrite_out_pipe_4  = regwrite_q;
    assign read_data_out_pipe_4 = read_data_q;
    assign aluResult_out_pipe_4 = alu_result_q;
    assign write_reg_out_pipe_4 = write_reg_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// tb/tb_mem_wb_stage.sv - directed self-checking bench for mem_wb_stage

module tb_mem_wb_stage;

    logic        clk;
    logic        rst;
    logic        en;
    logic        branch;
    logic        mem_write;
    logic        mem_read;
    logic        mem_to_reg;
    logic        reg_write;
    logic        zero;
    logic [15:0] target;
    logic [15:0] alu;
    logic [15:0] wdata;
    logic [2:0]  wreg;
    logic        pc_src;
    logic [15:0] target_mem;
    logic        stall;
    logic        m2r_o;
    logic        rw_o;
    logic [15:0] rdata_o;
    logic [15:0] alu_o;
    logic [2:0]  wreg_o;

    int checks = 0;
    int errors = 0;

    mem_wb_stage #(.DATA_W(16), .ADDR_W(8)) dut (
        .clk                      (clk),
        .rst                      (rst),
        .en                       (en),
        .branch_out_pipe_3        (branch),
        .memWrite_out_pipe_3      (mem_write),
        .memRead_out_pipe_3       (mem_read),
        .memtoReg_out_pipe_3      (mem_to_reg),
        .regWrite_out_pipe_3      (reg_write),
        .zero_out_pipe_3          (zero),
        .branch_target_out_pipe_3 (target),
        .aluResult_out_pipe_3     (alu),
        .read_data_2_out_pipe_3   (wdata),
        .write_reg_ex_out_pipe_3  (wreg),
        .pcSrc                    (pc_src),
        .branch_target_mem        (target_mem),
        .stall                    (stall),
        .memtoReg_out_pipe_4      (m2r_o),
        .regWrite_out_pipe_4      (rw_o),
        .read_data_out_pipe_4     (rdata_o),
        .aluResult_out_pipe_4     (alu_o),
        .write_reg_out_pipe_4     (wreg_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One instruction through the stage; with the wait-state build a load
    // first produces a stall cycle and a WB bubble.
    task automatic advance(input string tag);
`ifdef MEM_WAIT_STATE_EN
        if (mem_read) begin
            check({tag, "_stall_pre"}, {15'd0, stall}, 16'd1);
            step();
            check({tag, "_bubble_rw"}, {15'd0, rw_o}, 16'd0);
            check({tag, "_bubble_m2r"}, {15'd0, m2r_o}, 16'd0);
            check({tag, "_stall_post"}, {15'd0, stall}, 16'd0);
        end
`else
        check({tag, "_stall"}, {15'd0, stall}, 16'd0);
`endif
        step();
    endtask

    task automatic set_op(input logic mw, input logic mr, input logic m2r, input logic rw,
                          input logic [15:0] a, input logic [15:0] d, input logic [2:0] r);
        mem_write  = mw;
        mem_read   = mr;
        mem_to_reg = m2r;
        reg_write  = rw;
        alu        = a;
        wdata      = d;
        wreg       = r;
    endtask

    initial begin
        rst    = 1'b1;
        en     = 1'b1;
        branch = 1'b0;
        zero   = 1'b0;
        target = 16'h0000;
        set_op(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 3'd0);

        // Reset state
        step();
        check("rst_m2r", {15'd0, m2r_o}, 16'd0);
        check("rst_rw", {15'd0, rw_o}, 16'd0);
        check("rst_rdata", rdata_o, 16'h0000);
        check("rst_alu", alu_o, 16'h0000);
        check("rst_wreg", {13'd0, wreg_o}, 16'd0);
        rst = 1'b0;

        // Store 0x00AB at 5, then load it back into r3
        set_op(1'b1, 1'b0, 1'b0, 1'b0, 16'h0005, 16'h00AB, 3'd1);
        advance("st5");
        check("st5_rw", {15'd0, rw_o}, 16'd0);
        check("st5_alu", alu_o, 16'h0005);
        set_op(1'b0, 1'b1, 1'b1, 1'b1, 16'h0005, 16'h0000, 3'd3);
        advance("ld5");
        check("ld5_rdata", rdata_o, 16'h00AB);
        check("ld5_m2r", {15'd0, m2r_o}, 16'd1);
        check("ld5_rw", {15'd0, rw_o}, 16'd1);
        check("ld5_wreg", {13'd0, wreg_o}, 16'd3);

        // Branch resolution is combinational
        branch = 1'b1; zero = 1'b1; target = 16'd15;
        #1;
        check("br_taken", {15'd0, pc_src}, 16'd1);
        check("br_target", target_mem, 16'd15);
        zero = 1'b0;
        #1;
        check("br_zero0", {15'd0, pc_src}, 16'd0);
        branch = 1'b0; zero = 1'b1; target = 16'h0ABC;
        #1;
        check("br_nobranch", {15'd0, pc_src}, 16'd0);
        check("br_target2", target_mem, 16'h0ABC);
        zero = 1'b0;

        // Simultaneous read/write returns the old word
        set_op(1'b1, 1'b0, 1'b0, 1'b0, 16'h0007, 16'h0003, 3'd0);
        advance("st7");
        set_op(1'b1, 1'b1, 1'b1, 1'b1, 16'h0007, 16'h000A, 3'd6);
        advance("rw7");
        check("rw7_rdata_old", rdata_o, 16'h0003);
        check("rw7_wreg", {13'd0, wreg_o}, 16'd6);
        set_op(1'b0, 1'b1, 1'b1, 1'b1, 16'h0007, 16'h0000, 3'd2);
        advance("ld7");
        check("ld7_rdata_new", rdata_o, 16'h000A);
        check("ld7_wreg", {13'd0, wreg_o}, 16'd2);

        // en low: nothing moves, memory untouched
        en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            set_op(1'b1, i[0], 1'b0, 1'b0, 16'h0007 + 16'(i * 8), 16'hFFFF, 3'd5);
            mem_write = 1'b1;
            alu       = 16'h0007;
            step();
            check("hold_rdata", rdata_o, 16'h000A);
            check("hold_alu", alu_o, 16'h0007);
            check("hold_wreg", {13'd0, wreg_o}, 16'd2);
            check("hold_rw", {15'd0, rw_o}, 16'd1);
        end
        en = 1'b1;
        set_op(1'b0, 1'b1, 1'b1, 1'b1, 16'h0007, 16'h0000, 3'd4);
        advance("resume");
        check("resume_rdata", rdata_o, 16'h000A);
        check("resume_wreg", {13'd0, wreg_o}, 16'd4);

        // Address wrap: 0x0105 aliases 0x0005; a store still captures the old word
        set_op(1'b1, 1'b0, 1'b0, 1'b0, 16'h0105, 16'h1234, 3'd0);
        advance("wrap_st");
        check("wrap_st_rdata_old", rdata_o, 16'h00AB);
        check("wrap_st_alu", alu_o, 16'h0105);
        set_op(1'b0, 1'b1, 1'b1, 1'b1, 16'h0005, 16'h0000, 3'd7);
        advance("wrap_ld");
        check("wrap_ld_rdata", rdata_o, 16'h1234);
        check("wrap_ld_alu", alu_o, 16'h0005);

        // Asynchronous reset mid-cycle with every input high
        branch = 1'b1; zero = 1'b1; target = 16'hFFFF;
        set_op(1'b1, 1'b1, 1'b1, 1'b1, 16'hFFFF, 16'hFFFF, 3'd7);
        #2;
        rst = 1'b1;
        #1;
        check("arst_m2r", {15'd0, m2r_o}, 16'd0);
        check("arst_rw", {15'd0, rw_o}, 16'd0);
        check("arst_rdata", rdata_o, 16'h0000);
        check("arst_alu", alu_o, 16'h0000);
        check("arst_wreg", {13'd0, wreg_o}, 16'd0);
        step();
        check("arst_hold_alu", alu_o, 16'h0000);
        rst = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
